// File: rtl/player_move_ctrl_pkg.sv
// Shared types for the player movement controller: barrier records,
// move directions, mover FSM states and the "no hit" marker.
package player_move_ctrl_pkg;

  // One rectangular barrier: top-left corner plus height (width) and
  // horizontal extent (length), all in pixels.
  typedef struct packed {
    logic [31:0] rowstart;
    logic [31:0] colstart;
    logic [31:0] width;
    logic [31:0] length;
  } barrier_struct;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_SCAN   = 2'd2,
    ST_COMMIT = 2'd3
  } mover_state_e;

  localparam logic [6:0] HIT_NONE = 7'h7F;

  // Half-open interval overlap [a, a+alen) vs [b, b+blen), summed at 33 bits
  // so that large coordinates never wrap.
  function automatic logic span_overlap(input logic [31:0] a_start,
                                        input logic [31:0] a_len,
                                        input logic [31:0] b_start,
                                        input logic [31:0] b_len);
    logic [32:0] a_end;
    logic [32:0] b_end;
    a_end = {1'b0, a_start} + {1'b0, a_len};
    b_end = {1'b0, b_start} + {1'b0, b_len};
    return ({1'b0, a_start} < b_end) && ({1'b0, b_start} < a_end);
  endfunction

endpackage

// File: rtl/player_move_ctrl_box_overlap.sv
// Combinational test of the square player box against one barrier.
// Degenerate barriers (zero width or length) never hit, which keeps
// zero-filled map entries inert.
module player_move_ctrl_box_overlap
  import player_move_ctrl_pkg::*;
(
  input  logic [31:0]   i_cand_row,
  input  logic [31:0]   i_cand_col,
  input  logic [31:0]   i_size,
  input  barrier_struct i_barrier,
  output logic          o_hit
);

  logic w_nonempty;
  logic w_row_ov;
  logic w_col_ov;

  // Rectangle intersection: both axes must overlap and the barrier must have area
  always_comb begin
    w_nonempty = (i_barrier.width != 32'd0) && (i_barrier.length != 32'd0);
    w_row_ov   = span_overlap(i_cand_row, i_size, i_barrier.rowstart, i_barrier.width);
    w_col_ov   = span_overlap(i_cand_col, i_size, i_barrier.colstart, i_barrier.length);
    o_hit      = w_nonempty && w_row_ov && w_col_ov;
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Sequential collision-checked player mover. A move request is edge-checked
// and tested against barrier 0 in CALC, the remaining barriers are scanned
// one per clock in SCAN, and the move is committed in COMMIT when nothing hit.
// Optional feature: define MOVER_HIT_INDEX_EN to add the hit_index output.
module player_move_ctrl
  import player_move_ctrl_pkg::*;
#(
  parameter int NUM_BARRIERS = 34,
  parameter int PLAYER_SIZE  = 10,
  parameter int STEP         = 5,
  parameter int ROW_MAX      = 480,
  parameter int COL_MAX      = 640,
  parameter int START_ROW    = 15,
  parameter int START_COL    = 15
)(
  input  logic                  clk,
  input  logic                  reset,
  input  barrier_struct [100:0] barrier_array,
  input  logic                  restart,
  input  logic                  move_valid,
  input  logic [1:0]            move_dir,
  output logic                  move_ready,
  output logic [31:0]           player_row,
  output logic [31:0]           player_col,
  output logic                  move_done,
  output logic                  move_blocked
`ifdef MOVER_HIT_INDEX_EN
  ,
  output logic [6:0]            hit_index
`endif
);

  localparam logic [31:0] STEP_W  = 32'(STEP);
  localparam logic [31:0] SIZE_W  = 32'(PLAYER_SIZE);
  localparam logic [32:0] STEP_X  = 33'(STEP);
  localparam logic [32:0] SIZE_X  = 33'(PLAYER_SIZE);
  localparam logic [32:0] ROW_X   = 33'(ROW_MAX);
  localparam logic [32:0] COL_X   = 33'(COL_MAX);
  localparam logic [31:0] SROW_W  = 32'(START_ROW);
  localparam logic [31:0] SCOL_W  = 32'(START_COL);
  localparam logic [6:0]  LAST_IX = 7'(NUM_BARRIERS - 1);

  mover_state_e r_state;
  mover_state_e w_state_nxt;
  dir_e         r_dir;
  dir_e         w_dir_nxt;
  logic [6:0]   r_idx;
  logic [6:0]   w_idx_nxt;
  logic [31:0]  r_row;
  logic [31:0]  r_col;
  logic [31:0]  w_row_nxt;
  logic [31:0]  w_col_nxt;
  logic         r_done;
  logic         r_blocked;
  logic         w_done_nxt;
  logic         w_blocked_nxt;
  logic [31:0]  w_cand_row;
  logic [31:0]  w_cand_col;
  logic         w_edge_viol;
  logic         w_hit;
  logic [32:0]  w_row_ext;
  logic [32:0]  w_col_ext;
`ifdef MOVER_HIT_INDEX_EN
  logic [6:0]   r_hit_index;
  logic [6:0]   w_hit_index_nxt;
`endif

  // Candidate position and screen-edge check for the latched direction
  always_comb begin
    w_row_ext   = {1'b0, r_row};
    w_col_ext   = {1'b0, r_col};
    w_cand_row  = r_row;
    w_cand_col  = r_col;
    w_edge_viol = 1'b0;
    case (r_dir)
      DIR_UP: begin
        w_cand_row  = r_row - STEP_W;
        w_edge_viol = (r_row < STEP_W);
      end
      DIR_DOWN: begin
        w_cand_row  = r_row + STEP_W;
        w_edge_viol = ((w_row_ext + STEP_X + SIZE_X) > ROW_X);
      end
      DIR_LEFT: begin
        w_cand_col  = r_col - STEP_W;
        w_edge_viol = (r_col < STEP_W);
      end
      DIR_RIGHT: begin
        w_cand_col  = r_col + STEP_W;
        w_edge_viol = ((w_col_ext + STEP_X + SIZE_X) > COL_X);
      end
      default: begin
        w_cand_row  = r_row;
        w_cand_col  = r_col;
        w_edge_viol = 1'b1;
      end
    endcase
  end

  player_move_ctrl_box_overlap u_box_overlap (
    .i_cand_row (w_cand_row),
    .i_cand_col (w_cand_col),
    .i_size     (SIZE_W),
    .i_barrier  (barrier_array[r_idx]),
    .o_hit      (w_hit)
  );

  assign move_ready = (r_state == ST_IDLE) && !restart;

  // Next-state, scan index, position and pulse decisions
  always_comb begin
    w_state_nxt     = r_state;
    w_dir_nxt       = r_dir;
    w_idx_nxt       = r_idx;
    w_row_nxt       = r_row;
    w_col_nxt       = r_col;
    w_done_nxt      = 1'b0;
    w_blocked_nxt   = 1'b0;
`ifdef MOVER_HIT_INDEX_EN
    w_hit_index_nxt = r_hit_index;
`endif
    if (restart) begin
      w_state_nxt     = ST_IDLE;
      w_idx_nxt       = 7'd0;
      w_row_nxt       = SROW_W;
      w_col_nxt       = SCOL_W;
`ifdef MOVER_HIT_INDEX_EN
      w_hit_index_nxt = HIT_NONE;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (move_valid) begin
            w_dir_nxt   = dir_e'(move_dir);
            w_idx_nxt   = 7'd0;
            w_state_nxt = ST_CALC;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        // CALC also evaluates barrier 0 so barrier k resolves k cycles after an edge check
        ST_CALC, ST_SCAN: begin
          if ((r_state == ST_CALC) && w_edge_viol) begin
            w_blocked_nxt   = 1'b1;
            w_state_nxt     = ST_IDLE;
`ifdef MOVER_HIT_INDEX_EN
            w_hit_index_nxt = HIT_NONE;
`endif
          end else if (w_hit) begin
            w_blocked_nxt   = 1'b1;
            w_state_nxt     = ST_IDLE;
`ifdef MOVER_HIT_INDEX_EN
            w_hit_index_nxt = r_idx;
`endif
          end else if (r_idx == LAST_IX) begin
            w_state_nxt = ST_COMMIT;
          end else begin
            w_idx_nxt   = r_idx + 7'd1;
            w_state_nxt = ST_SCAN;
          end
        end
        ST_COMMIT: begin
          w_row_nxt   = w_cand_row;
          w_col_nxt   = w_cand_col;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, position and result pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_dir       <= DIR_UP;
      r_idx       <= 7'd0;
      r_row       <= SROW_W;
      r_col       <= SCOL_W;
      r_done      <= 1'b0;
      r_blocked   <= 1'b0;
`ifdef MOVER_HIT_INDEX_EN
      r_hit_index <= HIT_NONE;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_idx       <= w_idx_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_done      <= w_done_nxt;
      r_blocked   <= w_blocked_nxt;
`ifdef MOVER_HIT_INDEX_EN
      r_hit_index <= w_hit_index_nxt;
`endif
    end
  end

  assign player_row   = r_row;
  assign player_col   = r_col;
  assign move_done    = r_done;
  assign move_blocked = r_blocked;
`ifdef MOVER_HIT_INDEX_EN
  assign hit_index    = r_hit_index;
`endif

endmodule

// File: tb/tb_player_move_ctrl.sv
// Self-checking bench for player_move_ctrl: an event-level reference model
// predicts outcome and latency of each accepted move; a compare process
// checks every cycle, and directed scenarios pin the model with literals.
module tb_player_move_ctrl;
  import player_move_ctrl_pkg::*;

  localparam int N = 34, SZ = 10, STP = 5, RMAX = 480, CMAX = 640, SR = 15, SC = 15;

  logic clk = 1'b0;
  logic reset, restart, move_valid;
  logic [1:0] move_dir;
  barrier_struct [100:0] bar_s;
  logic move_ready, move_done, move_blocked;
  logic [31:0] player_row, player_col;
`ifdef MOVER_HIT_INDEX_EN
  logic [6:0] hit_index;
`endif

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  player_move_ctrl #(
    .NUM_BARRIERS(N), .PLAYER_SIZE(SZ), .STEP(STP), .ROW_MAX(RMAX),
    .COL_MAX(CMAX), .START_ROW(SR), .START_COL(SC)
  ) dut (
    .clk(clk), .reset(reset), .barrier_array(bar_s), .restart(restart),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .player_row(player_row), .player_col(player_col),
    .move_done(move_done), .move_blocked(move_blocked)
`ifdef MOVER_HIT_INDEX_EN
    , .hit_index(hit_index)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_edge = 0, m_evt = 0;
  bit m_busy = 0, m_outdone = 0, m_done = 0, m_blk = 0;
  longint m_row = SR, m_col = SC, m_crow = 0, m_ccol = 0;
  int m_hit = 127, m_khit = 127;

  function automatic bit box_hits(longint r, longint c, barrier_struct b);
    longint rs, cs, w, l;
    rs = longint'(b.rowstart); cs = longint'(b.colstart);
    w = longint'(b.width); l = longint'(b.length);
    if (w == 0 || l == 0) return 1'b0;
    return (r < rs + w) && (rs < r + SZ) && (c < cs + l) && (cs < c + SZ);
  endfunction

  function automatic void predict(input int d);
    bit edge_v;
    int k;
    int lat;
    m_crow = m_row; m_ccol = m_col; edge_v = 1'b0;
    case (d)
      0: begin edge_v = (m_row < STP);              m_crow = m_row - STP; end
      1: begin edge_v = (m_row + STP + SZ > RMAX);  m_crow = m_row + STP; end
      2: begin edge_v = (m_col < STP);              m_ccol = m_col - STP; end
      default: begin edge_v = (m_col + STP + SZ > CMAX); m_ccol = m_col + STP; end
    endcase
    if (edge_v) begin
      lat = 2; m_outdone = 1'b0; m_khit = 127;
    end else begin
      k = -1;
      for (int i = 0; i < N; i++) if (k < 0 && box_hits(m_crow, m_ccol, bar_s[i])) k = i;
      if (k >= 0) begin lat = 2 + k; m_outdone = 1'b0; m_khit = k; end
      else begin lat = N + 2; m_outdone = 1'b1; end
    end
    m_evt = m_edge + lat - 1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      m_edge++;
      m_done = 1'b0; m_blk = 1'b0;
      if (reset) begin
        m_busy = 1'b0; m_row = SR; m_col = SC; m_hit = 127;
      end else if (restart) begin
        m_busy = 1'b0; m_row = SR; m_col = SC; m_hit = 127;
      end else if (m_busy) begin
        if (m_edge == m_evt) begin
          m_busy = 1'b0;
          if (m_outdone) begin m_done = 1'b1; m_row = m_crow; m_col = m_ccol; end
          else begin m_blk = 1'b1; m_hit = m_khit; end
        end
      end else if (move_valid) begin
        predict(int'(move_dir));
        m_busy = 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("done", longint'(move_done), longint'(m_done));
      chk("blocked", longint'(move_blocked), longint'(m_blk));
      chk("row", longint'(player_row), m_row);
      chk("col", longint'(player_col), m_col);
      chk("ready", longint'(move_ready), longint'(!m_busy && !restart));
`ifdef MOVER_HIT_INDEX_EN
      chk("hit_index", longint'(hit_index), longint'(m_hit));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic void set_bar(int i, int rs, int cs, int w, int l);
    bar_s[i] = '{rowstart: 32'(rs), colstart: 32'(cs), width: 32'(w), length: 32'(l)};
  endfunction

  task automatic do_restart();
    @(posedge clk); #1 restart = 1'b1; move_valid = 1'b0;
    @(posedge clk); #1 restart = 1'b0;
  endtask

  task automatic do_move(input logic [1:0] d, output int lat, output bit ok);
    @(posedge clk); #1 move_valid = 1'b1; move_dir = d;
    @(posedge clk); #1 move_valid = 1'b0;
    lat = 0; ok = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (move_done || move_blocked) begin lat = n; ok = move_done; break; end
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL move_timeout: got no pulse within 200 cycles, required one");
    end
  endtask

  int lat, n1, n2, c1, c2;
  bit ok;

  initial begin
    reset = 1'b1; restart = 1'b0; move_valid = 1'b0; move_dir = 2'd0; bar_s = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; chk_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_row", longint'(player_row), 15);
      chk("rst_col", longint'(player_col), 15);
      chk("rst_ready", longint'(move_ready), 1);
      chk("rst_pulse", longint'(move_done | move_blocked), 0);
    end

    // Barrier 0 map: walk to (85,120), then a clear DOWN and a blocked DOWN
    bar_s = '0; set_bar(0, 100, 100, 10, 50); do_restart();
    for (int i = 0; i < 21; i++) do_move(2'd3, lat, ok);
    for (int i = 0; i < 14; i++) do_move(2'd1, lat, ok);
    chk("pos85_row", longint'(player_row), 85);
    chk("pos85_col", longint'(player_col), 120);
    do_move(2'd1, lat, ok);
    chk("down_lat", lat, 36); chk("down_ok", ok, 1);
    chk("down_row", longint'(player_row), 90); chk("down_col", longint'(player_col), 120);
    do_move(2'd1, lat, ok);
    chk("hit0_lat", lat, 2); chk("hit0_ok", ok, 0);
    chk("hit0_row", longint'(player_row), 90);
`ifdef MOVER_HIT_INDEX_EN
    chk("hit0_idx", longint'(hit_index), 0);
`endif

    // Screen edges: col==STEP is allowed, col 0 LEFT is blocked without scan
    bar_s = '0; do_restart();
    for (int i = 0; i < 3; i++) do_move(2'd2, lat, ok);
    chk("left0_col", longint'(player_col), 0); chk("left0_lat", lat, 36);
    do_move(2'd2, lat, ok);
    chk("ledge_lat", lat, 2); chk("ledge_ok", ok, 0); chk("ledge_col", longint'(player_col), 0);
`ifdef MOVER_HIT_INDEX_EN
    chk("ledge_idx", longint'(hit_index), 127);
`endif
    for (int i = 0; i < 3; i++) do_move(2'd0, lat, ok);
    do_move(2'd0, lat, ok);
    chk("uedge_lat", lat, 2); chk("uedge_row", longint'(player_row), 0);
    for (int i = 0; i < 94; i++) do_move(2'd1, lat, ok);
    chk("bottom_row", longint'(player_row), 470);
    do_move(2'd1, lat, ok);
    chk("dedge_lat", lat, 2); chk("dedge_ok", ok, 0);

    // Last scanned index blocks; the first unscanned index is inert
    bar_s = '0; set_bar(33, 20, 0, 10, 50); do_restart();
    do_move(2'd1, lat, ok);
    chk("hit33_lat", lat, 35); chk("hit33_ok", ok, 0); chk("hit33_row", longint'(player_row), 15);
`ifdef MOVER_HIT_INDEX_EN
    chk("hit33_idx", longint'(hit_index), 33);
`endif
    bar_s = '0; set_bar(34, 20, 0, 10, 50); do_restart();
    do_move(2'd1, lat, ok);
    chk("ix34_lat", lat, 36); chk("ix34_row", longint'(player_row), 20);

    // move_valid held high: back-to-back commits every 36 cycles
    bar_s = '0; do_restart();
    @(posedge clk); #1 move_valid = 1'b1; move_dir = 2'd3;
    @(posedge clk);
    n1 = 0; n2 = 0; c1 = 0; c2 = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (move_done && n1 == 0) begin n1 = n; c1 = int'(player_col); end
      else if (move_done && n2 == 0) begin n2 = n; c2 = int'(player_col); end
    end
    chk("cont_n1", n1, 36); chk("cont_c1", c1, 20);
    chk("cont_n2", n2, 72); chk("cont_c2", c2, 25);
    @(posedge clk); #1 move_valid = 1'b0;

    // restart together with move_valid in the middle of a scan
    repeat (40) @(posedge clk);
    #1 move_valid = 1'b1; move_dir = 2'd1;
    @(posedge clk); #1 move_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 restart = 1'b1; move_valid = 1'b1;
    @(negedge clk);
    chk("rs_ready_lo", longint'(move_ready), 0);
    @(posedge clk); #1 restart = 1'b0; move_valid = 1'b0;
    @(negedge clk);
    chk("rs_ready_hi", longint'(move_ready), 1);
    chk("rs_row", longint'(player_row), 15); chk("rs_col", longint'(player_col), 15);
    chk("rs_pulse", longint'(move_done | move_blocked), 0);
    repeat (40) @(posedge clk);

    // Randomized traffic with occasional restarts and fresh maps
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 299) == 0) begin
        restart = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          bar_s = '0;
          for (int j = 0; j < 6; j++)
            set_bar($urandom_range(0, 40), $urandom_range(0, 470), $urandom_range(0, 630),
                    $urandom_range(0, 80), $urandom_range(0, 80));
        end
      end else begin
        restart = 1'b0;
      end
      move_valid = ($urandom_range(0, 2) != 0);
      move_dir = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1 restart = 1'b0; move_valid = 1'b0;
    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
